// File: rtl/led_ctrl_pkg.sv
// Shared encodings and constants for the LED pattern sequencer.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [15:0] SEED_ONEHOT = 16'h0001;
   localparam logic [15:0] SEED_COUNT  = 16'h0000;
   localparam logic [1:0]  SPEED_MAX   = 2'd3;

   function automatic logic [15:0] mode_seed(input mode_e mode);
      return (mode == MODE_COUNT) ? SEED_COUNT : SEED_ONEHOT;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable-period strobe: counts 0..limit and pulses tick on the terminal count.
module tick_gen #(
   parameter int unsigned C_CNT_W = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [C_CNT_W-1:0] limit,
   input  logic               hold,
   input  logic               clear,
   output logic               tick
);

   logic [C_CNT_W-1:0] cnt_q, cnt_d;

   assign tick = ~hold & (cnt_q == limit);

   // clear wins over hold so button actions while paused still restart the period
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (tick) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 16-LED sequencer: button-selected pattern mode, 4-level update rate and pause.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned C_BASE_COUNT = 10_000_000 - 1,
   parameter int unsigned C_CNT_W      = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_mode,
   input  logic        btn_faster,
   input  logic        btn_slower,
   input  logic        btn_pause,
   output logic [15:0] led_out,
   output logic [1:0]  mode_out,
   output logic [1:0]  speed_out,
   output logic        paused_out
);

   localparam int unsigned PERIOD = C_BASE_COUNT + 1;

   logic [15:0]        led_q, led_d;
   mode_e              mode_q, mode_d;
   logic [1:0]         speed_q, speed_d;
   dir_e               dir_q, dir_d;
   logic               paused_q, paused_d;

   logic [31:0]        period_s;
   logic [C_CNT_W-1:0] limit;
   logic               tick;
   logic               speed_up, speed_dn, speed_chg, cnt_clear;

   always_comb begin
      period_s = 32'(PERIOD) >> speed_q;
      limit    = C_CNT_W'(period_s - 32'd1);
   end

   // Simultaneous faster+slower cancel; saturated presses must not disturb the counter
   assign speed_up  = btn_faster & ~btn_slower & (speed_q != SPEED_MAX);
   assign speed_dn  = btn_slower & ~btn_faster & (speed_q != 2'd0);
   assign speed_chg = speed_up | speed_dn;
   assign cnt_clear = btn_mode | speed_chg;

   tick_gen #(
      .C_CNT_W (C_CNT_W)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .limit   (limit),
      .hold    (paused_q),
      .clear   (cnt_clear),
      .tick    (tick)
   );

   always_comb begin
      led_d    = led_q;
      mode_d   = mode_q;
      speed_d  = speed_q;
      dir_d    = dir_q;
      paused_d = paused_q ^ btn_pause;

      if (speed_up) begin
         speed_d = speed_q + 2'd1;
      end else if (speed_dn) begin
         speed_d = speed_q - 2'd1;
      end

      if (btn_mode) begin
         mode_d = mode_e'(mode_q + 2'd1);
         led_d  = mode_seed(mode_d);
         dir_d  = DIR_LEFT;
      end else if (tick && !speed_chg) begin
         unique case (mode_q)
            MODE_ROT_L: led_d = {led_q[14:0], led_q[15]};
            MODE_ROT_R: led_d = {led_q[0], led_q[15:1]};
            MODE_BOUNCE: begin
               // Reverse at the end bit so the end LED is shown for exactly one period
               if (dir_q == DIR_LEFT) begin
                  if (led_q[15]) begin
                     led_d = led_q >> 1;
                     dir_d = DIR_RIGHT;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     led_d = led_q << 1;
                     dir_d = DIR_LEFT;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            MODE_COUNT: led_d = led_q + 16'd1;
            default: led_d = led_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_q    <= SEED_ONEHOT;
         mode_q   <= MODE_ROT_L;
         speed_q  <= 2'd0;
         dir_q    <= DIR_LEFT;
         paused_q <= 1'b0;
      end else begin
         led_q    <= led_d;
         mode_q   <= mode_d;
         speed_q  <= speed_d;
         dir_q    <= dir_d;
         paused_q <= paused_d;
      end
   end

   assign led_out    = led_q;
   assign mode_out   = mode_q;
   assign speed_out  = speed_q;
   assign paused_out = paused_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed vector bench for led_pattern_ctrl with C_BASE_COUNT = 7 (periods 8/4/2/1).
module tb_led_pattern_ctrl;

   logic        clk;
   logic        reset_n;
   logic        btn_mode, btn_faster, btn_slower, btn_pause;
   logic [15:0] led_out;
   logic [1:0]  mode_out, speed_out;
   logic        paused_out;

   int checks = 0;
   int errors = 0;

   led_pattern_ctrl #(
      .C_BASE_COUNT (7),
      .C_CNT_W      (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_mode   (btn_mode),
      .btn_faster (btn_faster),
      .btn_slower (btn_slower),
      .btn_pause  (btn_pause),
      .led_out    (led_out),
      .mode_out   (mode_out),
      .speed_out  (speed_out),
      .paused_out (paused_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        b_mode;
      logic        b_fast;
      logic        b_slow;
      logic        b_pause;
      int          idle;
      logic [15:0] led;
      logic [1:0]  mode;
      logic [1:0]  speed;
      logic        paused;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic bm, input logic bf, input logic bs, input logic bp,
                      input int idle, input logic [15:0] led, input logic [1:0] mode,
                      input logic [1:0] speed, input logic paused);
      vec_t v;
      v.b_mode = bm; v.b_fast = bf; v.b_slow = bs; v.b_pause = bp;
      v.idle = idle; v.led = led; v.mode = mode; v.speed = speed; v.paused = paused;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] led, input logic [1:0] mode,
                            input logic [1:0] speed, input logic paused);
      check({tag, ".led"}, led_out, led);
      check({tag, ".mode"}, {14'd0, mode_out}, {14'd0, mode});
      check({tag, ".speed"}, {14'd0, speed_out}, {14'd0, speed});
      check({tag, ".paused"}, {15'd0, paused_out}, {15'd0, paused});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic bm, input logic bf, input logic bs, input logic bp);
      btn_mode = bm; btn_faster = bf; btn_slower = bs; btn_pause = bp;
      step();
      btn_mode = 1'b0; btn_faster = 1'b0; btn_slower = 1'b0; btn_pause = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      btn_mode = 0; btn_faster = 0; btn_slower = 0; btn_pause = 0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (2) step();
      check_all("reset", 16'h0001, 2'd0, 2'd0, 1'b0);
      reset_n = 1'b1;

      //  mode fast slow pause idle  led       mode speed paused
      add(0, 0, 0, 0,     6, 16'h0001, 0, 0, 0);   // just before first tick
      add(0, 0, 0, 0,     0, 16'h0002, 0, 0, 0);   // first tick after 8 cycles
      add(0, 0, 0, 0,     7, 16'h0004, 0, 0, 0);
      add(0, 0, 0, 0,    15, 16'h0010, 0, 0, 0);
      add(0, 1, 0, 0,     0, 16'h0010, 0, 1, 0);
      add(0, 1, 0, 0,     0, 16'h0010, 0, 2, 0);
      add(0, 1, 0, 0,     0, 16'h0010, 0, 3, 0);
      add(0, 1, 0, 0,     0, 16'h0020, 0, 3, 0);   // saturated press, tick still applies
      add(0, 0, 0, 0,     2, 16'h0100, 0, 3, 0);   // one step per cycle
      add(0, 0, 1, 0,     0, 16'h0100, 0, 2, 0);   // tick dropped by speed change
      add(0, 0, 1, 0,     0, 16'h0100, 0, 1, 0);
      add(0, 0, 1, 0,     0, 16'h0100, 0, 0, 0);
      add(0, 0, 1, 0,     0, 16'h0100, 0, 0, 0);   // saturated, counter keeps running
      add(0, 0, 0, 0,     5, 16'h0100, 0, 0, 0);
      add(0, 0, 0, 0,     0, 16'h0200, 0, 0, 0);
      add(0, 1, 1, 0,     0, 16'h0200, 0, 0, 0);   // both speed buttons ignored
      add(0, 0, 0, 0,     6, 16'h0400, 0, 0, 0);
      add(1, 0, 0, 0,     0, 16'h0001, 1, 0, 0);
      add(1, 0, 0, 0,     0, 16'h0001, 2, 0, 0);
      add(0, 1, 0, 0,     0, 16'h0001, 2, 1, 0);
      add(0, 1, 0, 0,     0, 16'h0001, 2, 2, 0);
      add(0, 1, 0, 0,     0, 16'h0001, 2, 3, 0);
      add(0, 0, 0, 0,    14, 16'h8000, 2, 3, 0);
      add(0, 0, 0, 0,     0, 16'h4000, 2, 3, 0);   // bounce reverses
      add(0, 0, 0, 0,     0, 16'h2000, 2, 3, 0);
      add(0, 0, 0, 0,    12, 16'h0001, 2, 3, 0);
      add(0, 0, 0, 0,     0, 16'h0002, 2, 3, 0);   // bounce off bit 0
      add(1, 0, 0, 0,     0, 16'h0000, 3, 3, 0);   // mode beats coincident tick
      add(0, 0, 0, 0,     0, 16'h0001, 3, 3, 0);
      add(0, 0, 0, 0, 65533, 16'hFFFF, 3, 3, 0);
      add(0, 0, 0, 0,     0, 16'h0000, 3, 3, 0);   // count wraps
      add(0, 0, 0, 0,     0, 16'h0001, 3, 3, 0);
      add(0, 0, 1, 0,     0, 16'h0001, 3, 2, 0);
      add(0, 0, 1, 0,     0, 16'h0001, 3, 1, 0);
      add(0, 0, 1, 0,     0, 16'h0001, 3, 0, 0);
      add(0, 0, 0, 0,     7, 16'h0002, 3, 0, 0);
      add(0, 0, 0, 1,     0, 16'h0002, 3, 0, 1);
      add(0, 0, 0, 0,    19, 16'h0002, 3, 0, 1);   // held while paused
      add(1, 0, 0, 0,     0, 16'h0001, 0, 0, 1);   // mode acts while paused
      add(0, 0, 0, 1,     0, 16'h0001, 0, 0, 0);
      add(0, 0, 0, 0,     6, 16'h0001, 0, 0, 0);   // full period after resume
      add(0, 0, 0, 0,     0, 16'h0002, 0, 0, 0);
      add(0, 0, 0, 0,     6, 16'h0002, 0, 0, 0);
      add(0, 0, 0, 1,     0, 16'h0004, 0, 0, 1);   // tick with pause press still applied
      add(0, 0, 0, 0,     3, 16'h0004, 0, 0, 1);
      add(0, 0, 0, 1,     0, 16'h0004, 0, 0, 0);
      add(0, 0, 0, 0,     6, 16'h0004, 0, 0, 0);
      add(1, 0, 0, 0,     0, 16'h0001, 1, 0, 0);   // mode at terminal count
      add(0, 0, 0, 0,     7, 16'h8000, 1, 0, 0);
      add(0, 0, 0, 0,     7, 16'h4000, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         pulse(vecs[i].b_mode, vecs[i].b_fast, vecs[i].b_slow, vecs[i].b_pause);
         repeat (vecs[i].idle) step();
         check_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode, vecs[i].speed,
                   vecs[i].paused);
      end

      // Asynchronous reset mid-period from a non-reset state
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      step();
      check_all("pre_rst", 16'h4000, 2'd1, 2'd1, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      check_all("async_rst", 16'h0001, 2'd0, 2'd0, 1'b0);
      repeat (2) step();
      check_all("rst_held", 16'h0001, 2'd0, 2'd0, 1'b0);
      reset_n = 1'b1;
      repeat (7) step();
      check_all("post_rst7", 16'h0001, 2'd0, 2'd0, 1'b0);
      step();
      check_all("post_rst8", 16'h0002, 2'd0, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 16-LED display bank. Generates a programmable-rate update strobe and drives `led_out` through one of four patterns (rotate left, rotate right, bounce, binary count). Takes single-cycle pulses from the board's debounced buttons to select mode, adjust speed and pause. Sits between the button debouncers and the LED pins, replacing the fixed 1 Hz rotate counter.

## Interface
- `C_BASE_COUNT`, default 10_000_000-1: terminal count at speed 0. Gives 1 Hz from the 10 MHz clock. C_BASE_COUNT+1 must be a multiple of 8 and ≥ 8.
- `C_CNT_W`, default 24: tick counter width.
- `clk` in 1: 10 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: one-cycle pulse; advance to the next mode.
- `btn_faster` in 1: one-cycle pulse; speed + 1.
- `btn_slower` in 1: one-cycle pulse; speed − 1.
- `btn_pause` in 1: one-cycle pulse; toggle pause.
- `led_out` out 16: LED drive, registered.
- `mode_out` out 2: current mode (0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT).
- `speed_out` out 2: current speed level, 0..3.
- `paused_out` out 1: high while paused.

## Operation
- Reset values (async, on `reset_n` low): `led_out` = 16'h0001, mode = 0, speed = 0, paused = 0, tick counter = 0, bounce direction = left.
- Tick generator:
  - limit = ((C_BASE_COUNT+1) >> speed) − 1.
  - The counter counts 0..limit.
  - `tick` is high for one cycle when count == limit, and the counter returns to 0 on that cycle.
- On tick, `led_out` updates by mode:
  - ROT_L: {led[14:0], led[15]}.
  - ROT_R: {led[0], led[15:1]}.
  - BOUNCE: if direction is left, shift left. If led[15] is set while going left, shift right instead and set direction = right. Mirror rule applies at led[0]. Sequence: …0x4000, 0x8000, 0x4000…
  - COUNT: led + 1, wrapping 16'hFFFF → 16'h0000.
- `btn_mode`:
  - mode ← mode+1, wrapping 3 → 0.
  - `led_out` is reloaded with the seed: 0x0001 for modes 0–2, 0x0000 for COUNT.
  - Direction ← left; tick counter ← 0.
- `btn_faster` / `btn_slower`:
  - Speed saturates at 3 and at 0.
  - An effective change clears the tick counter. A saturated press is a no-op and does not clear the counter.
  - Both pressed in the same cycle: both ignored.
- `btn_pause`:
  - Toggles paused.
  - While paused, the tick counter holds, no ticks are issued, and `led_out` holds.
  - Mode and speed buttons still act while paused, including seed reload and counter clear.
- Same-cycle priority: `btn_mode` > speed change > tick.
  - A tick coinciding with an accepted mode or speed change is discarded.
  - `btn_pause` is independent. A tick coinciding with a pause press is still applied.

## Timing
- All outputs are registered.
- `led_out` changes on the clock edge that samples `tick`, i.e. it is visible the cycle after count == limit.
- Period at speed s is exactly (C_BASE_COUNT+1)>>s cycles.
- First update after reset release or a counter clear occurs limit+1 cycles later.
- Button effects are visible on `mode_out`, `speed_out`, `paused_out` and `led_out` one cycle after the pulse.
- Reset asserted mid-period restores all reset values immediately (asynchronous). No update is in flight afterwards.

## Structure
- Package `led_ctrl_pkg`:
  - mode encodings MODE_ROT_L/ROT_R/BOUNCE/COUNT;
  - SEED_ONEHOT = 16'h0001, SEED_COUNT = 16'h0000;
  - SPEED_MAX = 2'd3.
- Sub-module `tick_gen`: programmable-period strobe generator.
  - Inputs: `clk`, `reset_n`, `limit`, `hold`, `clear`.
  - Output: `tick`.
- Pattern next-state logic and button handling live in the top level.

## Test plan
All scenarios use C_BASE_COUNT = 7, giving periods of 8/4/2/1 cycles at speeds 0/1/2/3.
- Reset, no buttons, 40 cycles → `led_out` steps 0x0001 → 0x0002 → 0x0004 → 0x0008 → 0x0010, one step every 8 cycles.
- Press `btn_faster` ×4 → `speed_out` = 3 (4th press ignored) and `led_out` advances every cycle. Then `btn_slower` ×4 → `speed_out` = 0.
- `btn_mode` ×2, run to 0x8000 → next ticks give 0x4000 then 0x2000. Then `btn_mode` → `mode_out` = 3, `led_out` = 0x0000, then 0x0001 after 8 cycles.
- In COUNT mode, force 0xFFFF via ticks at speed 3 → next tick gives 0x0000.
- `btn_pause`, wait 20 cycles → `led_out` and `paused_out` = 1 held. `btn_mode` while paused → seed reloaded. Second `btn_pause` → resumes with a full period before the next update.
- Same-cycle cases: `btn_mode` coinciding with tick → mode advances, tick dropped. `btn_faster` and `btn_slower` together → speed unchanged. `reset_n` pulled low mid-period → outputs return to reset values asynchronously.
